// File: rtl/vis_mode_sequencer.sv
// Frame-synchronous visualizer mode sequencer: picks oSEL and oGAIN, switching only on VSync ticks.
// Optional gain fade through FADE_OUT/FADE_IN is enabled by defining VIS_MODE_SEQ_FADE_EN.
module vis_mode_sequencer #(
    parameter int unsigned NUM_MODES       = 9,
    parameter int unsigned DWELL_FRAMES    = 256,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter bit          VS_POL          = 1'b1
) (
    input  logic        iCLK_50,
    input  logic        iRST,
    input  logic        iVGA_VS,
    input  logic [3:0]  iSW_MODE,
    input  logic        iAUTO,
    input  logic        iKEY_NEXT,
    output logic [3:0]  oSEL,
    output logic [3:0]  oGAIN,
    output logic        oSWITCHING,
    output logic [15:0] oFRAME_CNT
);

`ifdef VIS_MODE_SEQ_FADE_EN
    typedef enum logic [1:0] {SHOW, FADE_OUT, BLANK, FADE_IN} state_t;
`else
    typedef enum logic [0:0] {SHOW, BLANK} state_t;
`endif

    localparam logic [3:0]  MAX_SEL    = 4'(NUM_MODES - 1);
    localparam logic [3:0]  DEB_MAX    = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0]  BLANK_LAST = 4'(BLANK_FRAMES - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);

    logic [1:0]  vs_sync_q;
    logic        vs_prev_q;
    logic [1:0]  key_sync_q;
    logic        key_prev_q;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  gain_q, gain_d;
    logic        switching_q, switching_d;
    logic [15:0] frame_q, frame_d;
    logic        key_req_q, key_req_d;
    logic        auto_q, auto_d;
    logic [3:0]  prev_req_q, prev_req_d;
    logic [3:0]  stab_q, stab_d;
    logic [15:0] dwell_q, dwell_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  target_q, target_d;

    logic        tick;
    logic        key_fall;
    logic        auto_toggle;
    logic [3:0]  req_c;
    logic [3:0]  next_sel;
    logic [3:0]  stab_nxt;
    logic [3:0]  cand;
    logic        expire;
    logic        start;

    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) begin
            vs_sync_q  <= '0;
            vs_prev_q  <= 1'b0;
            key_sync_q <= '0;
            key_prev_q <= 1'b0;
        end else begin
            vs_sync_q  <= {vs_sync_q[0], iVGA_VS};
            vs_prev_q  <= vs_sync_q[1];
            key_sync_q <= {key_sync_q[0], iKEY_NEXT};
            key_prev_q <= key_sync_q[1];
        end
    end

    assign tick     = VS_POL ? (vs_sync_q[1] & ~vs_prev_q) : (~vs_sync_q[1] & vs_prev_q);
    assign key_fall = key_prev_q & ~key_sync_q[1];

    assign auto_toggle = (iAUTO != auto_q);
    assign req_c       = (iSW_MODE > MAX_SEL) ? MAX_SEL : iSW_MODE;
    assign next_sel    = (sel_q == MAX_SEL) ? 4'd0 : sel_q + 4'd1;
    assign expire      = (dwell_q == DWELL_LAST);

    always_comb begin
        stab_nxt = stab_q;
        if (auto_toggle || (req_c != prev_req_q))
            stab_nxt = '0;
        else if (stab_q != DEB_MAX)
            stab_nxt = stab_q + 4'd1;
    end

    // Auto mode: key and dwell expiry merge into a single advance.
    always_comb begin
        cand  = req_c;
        start = 1'b0;
        if (iAUTO) begin
            cand  = next_sel;
            start = (key_req_q | expire) && (next_sel != sel_q);
        end else begin
            start = (stab_nxt == DEB_MAX) && (req_c != sel_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gain_d     = gain_q;
        frame_d    = frame_q;
        key_req_d  = key_req_q;
        auto_d     = auto_q;
        prev_req_d = prev_req_q;
        stab_d     = stab_q;
        dwell_d    = dwell_q;
        blank_d    = blank_q;
        target_d   = target_q;

        // A tick discards any pending key; an edge in the same cycle survives to the next frame.
        if (tick)
            key_req_d = 1'b0;
        if (key_fall)
            key_req_d = 1'b1;

        if (tick) begin
            frame_d    = frame_q + 16'd1;
            auto_d     = iAUTO;
            prev_req_d = req_c;
            stab_d     = stab_nxt;

            if (auto_toggle)
                dwell_d = '0;
            else if (state_q == SHOW && iAUTO)
                dwell_d = dwell_q + 16'd1;

            case (state_q)
                SHOW: begin
                    if (start) begin
                        target_d = cand;
                        dwell_d  = '0;
                        blank_d  = '0;
`ifdef VIS_MODE_SEQ_FADE_EN
                        state_d  = FADE_OUT;
`else
                        state_d  = BLANK;
                        gain_d   = 4'd0;
`endif
                    end
                end
                BLANK: begin
                    if (blank_q == 4'd0)
                        sel_d = target_q;
                    blank_d = blank_q + 4'd1;
                    if (blank_q == BLANK_LAST) begin
`ifdef VIS_MODE_SEQ_FADE_EN
                        state_d = FADE_IN;
`else
                        state_d = SHOW;
                        gain_d  = 4'd15;
`endif
                    end
                end
`ifdef VIS_MODE_SEQ_FADE_EN
                FADE_OUT: begin
                    gain_d = gain_q - 4'd1;
                    if (gain_q == 4'd1) begin
                        state_d = BLANK;
                        blank_d = '0;
                    end
                end
                FADE_IN: begin
                    gain_d = gain_q + 4'd1;
                    if (gain_q == 4'd14)
                        state_d = SHOW;
                end
`endif
                default: state_d = SHOW;
            endcase
        end

        switching_d = (state_d != SHOW);
    end

    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) begin
            state_q     <= SHOW;
            sel_q       <= '0;
            gain_q      <= '1;
            switching_q <= 1'b0;
            frame_q     <= '0;
            key_req_q   <= 1'b0;
            auto_q      <= 1'b0;
            prev_req_q  <= '0;
            stab_q      <= '0;
            dwell_q     <= '0;
            blank_q     <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gain_q      <= gain_d;
            switching_q <= switching_d;
            frame_q     <= frame_d;
            key_req_q   <= key_req_d;
            auto_q      <= auto_d;
            prev_req_q  <= prev_req_d;
            stab_q      <= stab_d;
            dwell_q     <= dwell_d;
            blank_q     <= blank_d;
            target_q    <= target_d;
        end
    end

    assign oSEL       = sel_q;
    assign oGAIN      = gain_q;
    assign oSWITCHING = switching_q;
    assign oFRAME_CNT = frame_q;

endmodule
